// File: rtl/expr_rpn_sequencer_pkg.sv
// Shared definitions for the RPN sequencer: FSM state encodings, ALU op codes,
// default sizes and the signed-overflow rule used when EXPR_OVERFLOW_CHECK_EN is set.
package expr_rpn_sequencer_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Add overflows on equal operand signs, sub on differing signs; both need a sign flip in the result.
    function automatic logic add_sub_overflow(input logic h, input logic a_msb,
                                              input logic b_msb, input logic r_msb);
        logic sign_cond;
        sign_cond = (h == OP_SUB) ? (a_msb != b_msb) : (a_msb == b_msb);
        return sign_cond && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/expr_stack.sv
// Operand stack: DEPTH x WIDTH register array with a depth counter,
// push / pop-two-push-one / clear controls and top / second-from-top read ports.
module expr_stack
    import expr_rpn_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW  = $clog2(DEPTH),
    localparam int CW  = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop2push1,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] second
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    sec_idx;

    // DEPTH is a power of two, so the low counter bits address the array directly.
    assign top_idx = AW'(count - CW'(1));
    assign sec_idx = AW'(count - CW'(2));
    assign full    = (count == CW'(DEPTH));
    assign top     = mem[top_idx];
    assign second  = mem[sec_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            count <= '0;
        end else if (push) begin
            mem[count[AW-1:0]] <= wr_data;
            count              <= count + CW'(1);
        end else if (pop2push1) begin
            mem[sec_idx] <= wr_data;
            count        <= count - CW'(1);
        end
    end

endmodule

// File: rtl/expr_rpn_sequencer.sv
// Reverse-Polish expression sequencer driving a combinational 16-bit ALU.
// Define EXPR_OVERFLOW_CHECK_EN to flag signed add/sub overflow as an expression error.
module expr_rpn_sequencer
    import expr_rpn_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_is_op,
    input  logic [WIDTH-1:0] tok_data,
    input  logic             tok_last,
    output logic             alu_h,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_error
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic             last_q, last_d;
    logic             alu_load;
    logic             st_push, st_pop, st_clear;
    logic             st_full;
    logic [CW-1:0]    st_count;
    logic [WIDTH-1:0] st_top, st_second;
    logic [WIDTH-1:0] st_wr_data;
    logic             tok_fire;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid-side outputs hold steady until that edge.
    assign tok_ready  = rst_n && (state_q == FETCH);
    assign tok_fire   = tok_valid && tok_ready;
    assign res_valid  = (state_q == DONE);
    assign res_error  = res_valid && (err_q || (st_count != CW'(1)));
    assign res_data   = (res_valid && !res_error) ? st_top : '0;
    assign st_wr_data = (state_q == EXEC) ? alu_result : tok_data;

    expr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (st_push),
        .pop2push1 (st_pop),
        .clear     (st_clear),
        .wr_data   (st_wr_data),
        .full      (st_full),
        .count     (st_count),
        .top       (st_top),
        .second    (st_second)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        last_d   = last_q;
        alu_load = 1'b0;
        st_push  = 1'b0;
        st_pop   = 1'b0;
        st_clear = 1'b0;
        case (state_q)
            FETCH: begin
                if (tok_fire) begin
                    if (!tok_is_op) begin
                        if (!err_q) begin
                            if (st_full) err_d = 1'b1;
                            else         st_push = 1'b1;
                        end
                        if (tok_last) state_d = DONE;
                    end else if (err_q || (st_count < CW'(2))) begin
                        // Errored expressions still drain tokens up to tok_last.
                        err_d = 1'b1;
                        if (tok_last) state_d = DONE;
                    end else begin
                        alu_load = 1'b1;
                        last_d   = tok_last;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                st_pop = 1'b1;
`ifdef EXPR_OVERFLOW_CHECK_EN
                if (add_sub_overflow(alu_h, alu_a[WIDTH-1], alu_b[WIDTH-1], alu_result[WIDTH-1]))
                    err_d = 1'b1;
`endif
                state_d = last_q ? DONE : FETCH;
            end
            DONE: begin
                if (res_ready) begin
                    st_clear = 1'b1;
                    err_d    = 1'b0;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            alu_h   <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            last_q  <= last_d;
            if (alu_load) begin
                alu_h <= tok_data[0];
                alu_a <= st_second;
                alu_b <= st_top;
            end
        end
    end

endmodule

// File: tb/tb_expr_rpn_sequencer.sv
// Bench for expr_rpn_sequencer: queue-based RPN evaluator model, directed expressions,
// per-cycle result comparison and a single summary line.
module tb_expr_rpn_sequencer;

    localparam int W = 16;
    localparam int D = 8;

    typedef struct packed { logic is_op; logic [W-1:0] data; } tok_t;
    typedef struct packed { logic h; logic [W-1:0] a; logic [W-1:0] b; } op_t;

    logic         clk;
    logic         rst_n;
    logic         tok_valid;
    logic         tok_ready;
    logic         tok_is_op;
    logic [W-1:0] tok_data;
    logic         tok_last;
    logic         alu_h;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_error;

    int checks   = 0;
    int failures = 0;

    logic [W:0]   exp_q[$];
    op_t          m_ops[$];
    bit           m_exec[$];
    logic         m_err;
    logic [W-1:0] m_data;

    expr_rpn_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_is_op  (tok_is_op),
        .tok_data   (tok_data),
        .tok_last   (tok_last),
        .alu_h      (alu_h),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_error  (res_error)
    );

    // The ALU the sequencer drives.
    assign alu_result = alu_h ? (alu_a - alu_b) : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic tok_t opd(input logic [W-1:0] v);
        tok_t t;
        t.is_op = 1'b0;
        t.data  = v;
        return t;
    endfunction

    function automatic tok_t opr(input logic s);
        tok_t t;
        t.is_op = 1'b1;
        t.data  = {{(W-1){1'b0}}, s};
        return t;
    endfunction

    // Evaluate an expression with a plain queue stack; record which tokens run the ALU.
    function automatic void model_eval(input tok_t toks[$]);
        logic [W-1:0] st[$];
        logic [W-1:0] a, b, r;
        int           sa, sb, sr;
        bit           err;
        op_t          o;
        err = 0;
        m_ops.delete();
        m_exec.delete();
        foreach (toks[i]) begin
            m_exec.push_back(1'b0);
            if (err) continue;
            if (!toks[i].is_op) begin
                if (st.size() == D) err = 1;
                else st.push_back(toks[i].data);
            end else if (st.size() < 2) begin
                err = 1;
            end else begin
                b = st.pop_back();
                a = st.pop_back();
                r = toks[i].data[0] ? a - b : a + b;
                o.h = toks[i].data[0];
                o.a = a;
                o.b = b;
                m_ops.push_back(o);
                m_exec[i] = 1'b1;
                sa = int'($signed(a));
                sb = int'($signed(b));
                sr = toks[i].data[0] ? sa - sb : sa + sb;
`ifdef EXPR_OVERFLOW_CHECK_EN
                if (sr > 32767 || sr < -32768) err = 1;
`endif
                st.push_back(r);
            end
        end
        if (st.size() != 1) err = 1;
        m_err  = err;
        m_data = err ? '0 : st[0];
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the token.
    task automatic send_tok(input tok_t t, input bit last, input bit exe, input op_t eop,
                            input string name);
        int n;
        tok_valid = 1'b1;
        tok_is_op = t.is_op;
        tok_data  = t.data;
        tok_last  = last;
        n = 0;
        while (!tok_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!tok_ready) begin
            check({name, "_tok_ready_timeout"}, tok_ready, 1);
            tok_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        tok_last  = 1'b0;
        if (exe) begin
            check({name, "_alu_h"}, alu_h, eop.h);
            check({name, "_alu_a"}, alu_a, eop.a);
            check({name, "_alu_b"}, alu_b, eop.b);
        end
    endtask

    task automatic wait_result(input int hold, input string name);
        int n;
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!res_valid) begin
            check({name, "_res_valid_timeout"}, res_valid, 1);
            return;
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
            check({name, "_hold_tok_ready"}, tok_ready, 0);
            check({name, "_hold_res_valid"}, res_valid, 1);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({name, "_post_res_valid"}, res_valid, 0);
        check({name, "_post_tok_ready"}, tok_ready, 1);
    endtask

    task automatic run_expr(input string name, input tok_t toks[$], input logic e_err,
                            input logic [W-1:0] e_data, input int hold);
        int  k;
        op_t none;
        none = '0;
        model_eval(toks);
        check({name, "_model_err"}, m_err, e_err);
        check({name, "_model_data"}, m_data, e_data);
        exp_q.push_back({m_err, m_data});
        k = 0;
        foreach (toks[i]) begin
            send_tok(toks[i], i == toks.size() - 1, m_exec[i], m_exec[i] ? m_ops[k] : none, name);
            if (m_exec[i]) k++;
        end
        if (m_exec[toks.size() - 1]) begin
            check({name, "_exec_res_valid"}, res_valid, 0);
            @(posedge clk);
            #1;
        end
        check({name, "_latency_res_valid"}, res_valid, 1);
        wait_result(hold, name);
    endtask

    // Result checker: every cycle the result is offered it must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", res_valid, 0);
            end else begin
                check("res_error", res_error, exp_q[0][W]);
                check("res_data", res_data, exp_q[0][W-1:0]);
                check("tok_ready_in_done", tok_ready, 0);
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        tok_t q[$];
        op_t  o;
        rst_n     = 1'b0;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = '0;
        tok_last  = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tok_ready", tok_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_error", res_error, 0);
        check("rst_alu_h", alu_h, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_tok_ready", tok_ready, 1);

        q = '{opd(3), opd(4), opr(0)};
        run_expr("add_3_4", q, 1'b0, 16'd7, 0);
        q = '{opd(10), opd(3), opr(1)};
        run_expr("sub_10_3", q, 1'b0, 16'd7, 0);
        q = '{opd(15), opd(15), opr(1), opd(2), opr(0)};
        run_expr("chain", q, 1'b0, 16'd2, 0);
        q = '{opd(0), opd(1), opr(1)};
        run_expr("wrap_sub", q, 1'b0, 16'hFFFF, 0);
        q = '{opd(5), opr(0), opd(1)};
        run_expr("underflow_absorb", q, 1'b1, 16'd0, 0);
        q = '{opd(5), opr(0)};
        run_expr("underflow_last", q, 1'b1, 16'd0, 0);
        q.delete();
        for (int i = 1; i <= 9; i++) q.push_back(opd(16'(i)));
        run_expr("stack_overflow", q, 1'b1, 16'd0, 0);
        q = '{opd(1), opd(2)};
        run_expr("depth_two", q, 1'b1, 16'd0, 0);
        q = '{opd(9), opd(4), opr(1)};
        run_expr("hold_ready", q, 1'b0, 16'd5, 3);

        // Reset while the ALU operation is in flight.
        o.h = 1'b0;
        o.a = 16'd3;
        o.b = 16'd4;
        send_tok(opd(3), 1'b0, 1'b0, '0, "rst_exec");
        send_tok(opd(4), 1'b0, 1'b0, '0, "rst_exec");
        send_tok(opr(0), 1'b1, 1'b1, o, "rst_exec");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu_h", alu_h, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_data", res_data, 0);
        check("mid_rst_res_error", res_error, 0);
        check("mid_rst_tok_ready", tok_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q = '{opd(1), opd(1), opr(0)};
        run_expr("after_rst", q, 1'b0, 16'd2, 0);

        q = '{opd(16'h7FFF), opd(1), opr(0)};
`ifdef EXPR_OVERFLOW_CHECK_EN
        run_expr("signed_ovf", q, 1'b1, 16'h0000, 0);
`else
        run_expr("signed_ovf", q, 1'b0, 16'h8000, 0);
`endif

        repeat (2) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
